// File: rtl/rob_fill_sink_pkg.sv
// Shared scoreboard/ROB definitions used by the ROB fill sink and its FIFO.
package rob_fill_sink_pkg;

    localparam int CMD_BLK_G     = 4;
    localparam logic [CMD_BLK_G-1:0] CMD_ROB_FILL = 4'd6;

    localparam int I_N_EX_PIP    = 3;
    localparam int I_BL_EX_PIP   = 3;
    localparam int I_BL_MARC_REG = 6;
    localparam int ROB_DATA_W    = 32;

    // Pipe id 0 is reserved to mean "nothing completes this cycle".
    localparam logic [I_BL_EX_PIP-1:0] PIP_DUMMY = '0;
    localparam logic [I_BL_EX_PIP-1:0] PIP_MAX   = I_BL_EX_PIP'(I_N_EX_PIP);

    typedef struct packed {
        logic [I_BL_MARC_REG-1:0] preg_rd;
        logic [ROB_DATA_W-1:0]    data;
    } ROB_FILL_ENT;

    function automatic logic pip_is_legal(input logic [I_BL_EX_PIP-1:0] pip);
        return (pip != PIP_DUMMY) && (pip <= PIP_MAX);
    endfunction

    function automatic logic pip_is_bad(input logic [I_BL_EX_PIP-1:0] pip);
        return pip > PIP_MAX;
    endfunction

endpackage

// File: rtl/rob_fill_sink_fifo.sv
// Small power-of-two FIFO; a push into a full FIFO only lands when a pop frees a slot in the same cycle.
module rob_fill_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 38
) (
    input  logic                         i_clk,
    input  logic                         i_clear_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_wdata,
    output logic [W-1:0]                 o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Storage is written without reset; stale slots are never visible because the pointers are cleared.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge i_clk) begin
        if (!i_clear_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_fill_sink.sv
// Receives scoreboard ROB-fill commands, queues {preg, data} and drains them to the register file with a wakeup broadcast.
module rob_fill_sink
    import rob_fill_sink_pkg::*;
#(
    parameter int DATA_W = ROB_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                                con_cmd_clk,
    input  logic                                con_cmd_clear,
    input  logic [I_BL_EX_PIP-1:0]              con_cmd_fill_insert_pip,
    input  logic [I_BL_MARC_REG-1:0]            con_cmd_fill_i_preg_rd,
    input  logic [I_N_EX_PIP-1:0][DATA_W-1:0]   pip_data,
    output logic                                wb_valid,
    output logic [I_BL_MARC_REG-1:0]            wb_preg_rd,
    output logic [DATA_W-1:0]                   wb_data,
    input  logic                                wb_ready,
    output logic                                wk_valid,
    output logic [I_BL_MARC_REG-1:0]            wk_preg,
    output logic [$clog2(DEPTH+1)-1:0]          fill_cnt,
    output logic                                err_ovf,
    output logic                                err_bad_pip
);

    localparam int ENT_W = I_BL_MARC_REG + DATA_W;

    logic                     w_accept;
    logic                     w_bad;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [DATA_W-1:0]        w_sel_data;
    logic [ENT_W-1:0]         w_head;
    logic                     r_wk_valid;
    logic [I_BL_MARC_REG-1:0] r_wk_preg;
    logic                     r_err_ovf;
    logic                     r_err_bad_pip;

    assign w_accept = pip_is_legal(con_cmd_fill_insert_pip);
    assign w_bad    = pip_is_bad(con_cmd_fill_insert_pip);

    // Pick the result bus of the completing pipe; pipe id k+1 lives in slot k.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < I_N_EX_PIP; k++) begin
            if (con_cmd_fill_insert_pip == I_BL_EX_PIP'(k + 1)) begin
                w_sel_data = pip_data[k];
            end
        end
    end

    assign wb_valid = !w_empty;
    assign w_pop    = wb_valid && wb_ready;
    assign {wb_preg_rd, wb_data} = w_head;

    rob_fill_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .i_clk     (con_cmd_clk),
        .i_clear_n (con_cmd_clear),
        .i_push    (w_accept),
        .i_pop     (w_pop),
        .i_wdata   ({con_cmd_fill_i_preg_rd, w_sel_data}),
        .o_rdata   (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (fill_cnt)
    );

    // Wakeup follows every accepted fill (even a dropped one); error flags stick until reset.
    always_ff @(posedge con_cmd_clk) begin
        if (!con_cmd_clear) begin
            r_wk_valid    <= 1'b0;
            r_wk_preg     <= '0;
            r_err_ovf     <= 1'b0;
            r_err_bad_pip <= 1'b0;
        end else begin
            r_wk_valid <= w_accept;
            if (w_accept) begin
                r_wk_preg <= con_cmd_fill_i_preg_rd;
            end
            if (w_accept && w_full && !w_pop) begin
                r_err_ovf <= 1'b1;
            end
            if (w_bad) begin
                r_err_bad_pip <= 1'b1;
            end
        end
    end

    assign wk_valid    = r_wk_valid;
    assign wk_preg     = r_wk_preg;
    assign err_ovf     = r_err_ovf;
    assign err_bad_pip = r_err_bad_pip;

endmodule

// File: tb/tb_rob_fill_sink.sv
// Self-checking bench for rob_fill_sink: directed scenarios plus a randomized run against a queue model.
module tb_rob_fill_sink;

    logic        clk = 1'b0;
    logic        clearN;
    logic [2:0]  insertPip;
    logic [5:0]  pregRd;
    logic [2:0][31:0] pipData;
    logic        wbReady;
    logic        wbValid;
    logic [5:0]  wbPregRd;
    logic [31:0] wbData;
    logic        wkValid;
    logic [5:0]  wkPreg;
    logic [2:0]  fillCnt;
    logic        errOvf;
    logic        errBadPip;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]  preg;
        logic [31:0] data;
    } entT;

    entT expQ[$];

    always #5 clk = ~clk;

    rob_fill_sink #(
        .DATA_W (32),
        .DEPTH  (4)
    ) dut (
        .con_cmd_clk             (clk),
        .con_cmd_clear           (clearN),
        .con_cmd_fill_insert_pip (insertPip),
        .con_cmd_fill_i_preg_rd  (pregRd),
        .pip_data                (pipData),
        .wb_valid                (wbValid),
        .wb_preg_rd              (wbPregRd),
        .wb_data                 (wbData),
        .wb_ready                (wbReady),
        .wk_valid                (wkValid),
        .wk_preg                 (wkPreg),
        .fill_cnt                (fillCnt),
        .err_ovf                 (errOvf),
        .err_bad_pip             (errBadPip)
    );

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic driveIdle();
        insertPip  = 3'd0;
        pregRd     = 6'($urandom);
        pipData[0] = $urandom;
        pipData[1] = $urandom;
        pipData[2] = $urandom;
    endtask

    task automatic driveFill(input int pip, input logic [5:0] preg, input logic [31:0] data);
        pipData[0]     = $urandom;
        pipData[1]     = $urandom;
        pipData[2]     = $urandom;
        pipData[pip-1] = data;
        insertPip      = 3'(pip);
        pregRd         = preg;
    endtask

    task automatic doReset();
        clearN  = 1'b0;
        wbReady = 1'b0;
        driveIdle();
        tick();
        tick();
        clearN = 1'b1;
        expQ.delete();
    endtask

    task automatic test_reset();
        doReset();
        if (fillCnt !== 3'd0) begin failures++; $display("[TB] FAIL reset_fill_cnt got=%0d exp=0", fillCnt); end
        checks++;
        if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_valid got=%0b exp=0", wbValid); end
        checks++;
        if (wkValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wk_valid got=%0b exp=0", wkValid); end
        checks++;
        if (wkPreg !== 6'd0) begin failures++; $display("[TB] FAIL reset_wk_preg got=%0d exp=0", wkPreg); end
        checks++;
        if (errOvf !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_ovf got=%0b exp=0", errOvf); end
        checks++;
        if (errBadPip !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_bad got=%0b exp=0", errBadPip); end
        checks++;
    endtask

    task automatic test_single_fill();
        doReset();
        wbReady = 1'b1;
        driveFill(2, 6'd7, 32'hDEAD_BEEF);
        tick();
        driveIdle();
        if (wbValid !== 1'b1) begin failures++; $display("[TB] FAIL single_wb_valid got=%0b exp=1", wbValid); end
        checks++;
        if (wbPregRd !== 6'd7) begin failures++; $display("[TB] FAIL single_wb_preg got=%0d exp=7", wbPregRd); end
        checks++;
        if (wbData !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL single_wb_data got=%0h exp=deadbeef", wbData); end
        checks++;
        if (wkValid !== 1'b1) begin failures++; $display("[TB] FAIL single_wk_valid got=%0b exp=1", wkValid); end
        checks++;
        if (wkPreg !== 6'd7) begin failures++; $display("[TB] FAIL single_wk_preg got=%0d exp=7", wkPreg); end
        checks++;
        tick();
        if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL single_wb_valid_after got=%0b exp=0", wbValid); end
        checks++;
        if (fillCnt !== 3'd0) begin failures++; $display("[TB] FAIL single_fill_cnt_after got=%0d exp=0", fillCnt); end
        checks++;
        if (wkValid !== 1'b0) begin failures++; $display("[TB] FAIL single_wk_pulse_width got=%0b exp=0", wkValid); end
        checks++;
    endtask

    task automatic test_overflow();
        entT e;
        doReset();
        wbReady = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            driveFill((i % 3) + 1, 6'(i), 32'hA000_0000 + 32'(i));
            if (i <= 4) begin
                e.preg = 6'(i);
                e.data = 32'hA000_0000 + 32'(i);
                expQ.push_back(e);
            end
            tick();
            if (i == 4) begin
                if (errOvf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_early_flag got=%0b exp=0", errOvf); end
                checks++;
            end
        end
        driveIdle();
        if (fillCnt !== 3'd4) begin failures++; $display("[TB] FAIL ovf_fill_cnt got=%0d exp=4", fillCnt); end
        checks++;
        if (errOvf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_err_flag got=%0b exp=1", errOvf); end
        checks++;
        if (wkValid !== 1'b1 || wkPreg !== 6'd5) begin
            failures++;
            $display("[TB] FAIL ovf_dropped_wakeup got=%0b/%0d exp=1/5", wkValid, wkPreg);
        end
        checks++;
        wbReady = 1'b1;
        for (int c = 0; c < 10 && expQ.size() != 0; c++) begin
            if (wbValid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ovf_drain_valid got=%0b exp=1", wbValid);
            end else begin
                e = expQ.pop_front();
                if (wbPregRd !== e.preg) begin failures++; $display("[TB] FAIL ovf_drain_preg got=%0d exp=%0d", wbPregRd, e.preg); end
                checks++;
                if (wbData !== e.data) begin failures++; $display("[TB] FAIL ovf_drain_data got=%0h exp=%0h", wbData, e.data); end
            end
            checks++;
            tick();
        end
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL ovf_drain_timeout left=%0d exp=0", expQ.size()); end
        checks++;
        if (wbValid !== 1'b0 || fillCnt !== 3'd0) begin
            failures++;
            $display("[TB] FAIL ovf_preg5_written got=%0b/%0d exp=0/0", wbValid, fillCnt);
        end
        checks++;
        if (errOvf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%0b exp=1", errOvf); end
        checks++;
    endtask

    task automatic test_back_to_back();
        entT e;
        int  idx;
        doReset();
        wbReady = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            driveFill(3, 6'(i), 32'hB000_0000 + 32'(i));
            e.preg = 6'(i);
            e.data = 32'hB000_0000 + 32'(i);
            expQ.push_back(e);
            tick();
            if (wkValid !== 1'b1 || wkPreg !== 6'(i)) begin
                failures++;
                $display("[TB] FAIL b2b_wakeup got=%0b/%0d exp=1/%0d", wkValid, wkPreg, i);
            end
            checks++;
        end
        driveIdle();
        if (fillCnt !== 3'd4) begin failures++; $display("[TB] FAIL full_fill_cnt got=%0d exp=4", fillCnt); end
        checks++;
        wbReady = 1'b1;
        driveFill(1, 6'd9, 32'hC0FF_EE09);
        e = expQ.pop_front();
        if (wbPregRd !== e.preg) begin failures++; $display("[TB] FAIL full_head_preg got=%0d exp=%0d", wbPregRd, e.preg); end
        checks++;
        e.preg = 6'd9;
        e.data = 32'hC0FF_EE09;
        expQ.push_back(e);
        tick();
        driveIdle();
        if (fillCnt !== 3'd4) begin failures++; $display("[TB] FAIL full_pushpop_cnt got=%0d exp=4", fillCnt); end
        checks++;
        if (errOvf !== 1'b0) begin failures++; $display("[TB] FAIL full_pushpop_ovf got=%0b exp=0", errOvf); end
        checks++;
        idx = 0;
        for (int c = 0; c < 10 && expQ.size() != 0; c++) begin
            if (wbValid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL full_drain_valid got=%0b exp=1", wbValid);
            end else begin
                idx++;
                e = expQ.pop_front();
                if (wbPregRd !== e.preg) begin failures++; $display("[TB] FAIL full_drain_preg got=%0d exp=%0d", wbPregRd, e.preg); end
                checks++;
                if (wbData !== e.data) begin failures++; $display("[TB] FAIL full_drain_data got=%0h exp=%0h", wbData, e.data); end
                checks++;
                if (e.preg == 6'd9 && idx != 4) begin failures++; $display("[TB] FAIL full_preg9_position got=%0d exp=4", idx); end
            end
            checks++;
            tick();
        end
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL full_drain_timeout left=%0d exp=0", expQ.size()); end
        checks++;
    endtask

    task automatic test_bad_pip();
        doReset();
        insertPip  = 3'd5;
        pregRd     = 6'd3;
        pipData[0] = $urandom;
        pipData[1] = $urandom;
        pipData[2] = $urandom;
        tick();
        insertPip = 3'd0;
        pregRd    = 6'd11;
        if (errBadPip !== 1'b1) begin failures++; $display("[TB] FAIL bad_err_flag got=%0b exp=1", errBadPip); end
        checks++;
        if (fillCnt !== 3'd0 || wbValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bad_no_push got=%0d/%0b exp=0/0", fillCnt, wbValid);
        end
        checks++;
        if (wkValid !== 1'b0) begin failures++; $display("[TB] FAIL bad_no_wakeup got=%0b exp=0", wkValid); end
        checks++;
        tick();
        if (errBadPip !== 1'b1) begin failures++; $display("[TB] FAIL bad_sticky got=%0b exp=1", errBadPip); end
        checks++;
        if (fillCnt !== 3'd0 || wkValid !== 1'b0 || errOvf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dummy_no_effect got=%0d/%0b/%0b exp=0/0/0", fillCnt, wkValid, errOvf);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        doReset();
        wbReady    = 1'b0;
        insertPip  = 3'd6;
        pregRd     = 6'd1;
        tick();
        for (int i = 0; i < 3; i++) begin
            driveFill(i + 1, 6'(20 + i), $urandom);
            tick();
        end
        driveIdle();
        if (fillCnt !== 3'd3 || errBadPip !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_setup got=%0d/%0b exp=3/1", fillCnt, errBadPip);
        end
        checks++;
        clearN = 1'b0;
        driveFill(1, 6'd12, 32'h1234_5678);
        tick();
        clearN = 1'b1;
        driveIdle();
        if (fillCnt !== 3'd0) begin failures++; $display("[TB] FAIL mid_fill_cnt got=%0d exp=0", fillCnt); end
        checks++;
        if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL mid_wb_valid got=%0b exp=0", wbValid); end
        checks++;
        if (wkValid !== 1'b0) begin failures++; $display("[TB] FAIL mid_wk_valid got=%0b exp=0", wkValid); end
        checks++;
        if (errOvf !== 1'b0 || errBadPip !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_err_flags got=%0b/%0b exp=0/0", errOvf, errBadPip);
        end
        checks++;
        tick();
        if (wbValid !== 1'b0 || wkValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_after got=%0b/%0b exp=0/0", wbValid, wkValid);
        end
        checks++;
    endtask

    task automatic test_random();
        entT         e;
        int          pip;
        logic [5:0]  preg;
        logic [31:0] data;
        logic        expWk;
        logic [5:0]  expWkPreg;
        logic        modelOvf;
        int          accepted;
        int          wkSeen;
        doReset();
        expWk     = 1'b0;
        expWkPreg = 6'd0;
        modelOvf  = 1'b0;
        accepted  = 0;
        wkSeen    = 0;
        for (int cyc = 0; cyc <= 10000; cyc++) begin
            if (wbValid !== (expQ.size() != 0)) begin
                failures++;
                $display("[TB] FAIL rnd_wb_valid cyc=%0d got=%0b exp=%0b", cyc, wbValid, expQ.size() != 0);
            end
            checks++;
            if (expQ.size() != 0 && wbValid === 1'b1) begin
                if (wbPregRd !== expQ[0].preg || wbData !== expQ[0].data) begin
                    failures++;
                    $display("[TB] FAIL rnd_head cyc=%0d got=%0d/%0h exp=%0d/%0h", cyc, wbPregRd, wbData, expQ[0].preg, expQ[0].data);
                end
                checks++;
            end
            if (fillCnt !== 3'(expQ.size())) begin
                failures++;
                $display("[TB] FAIL rnd_fill_cnt cyc=%0d got=%0d exp=%0d", cyc, fillCnt, expQ.size());
            end
            checks++;
            if (wkValid !== expWk || (expWk && wkPreg !== expWkPreg)) begin
                failures++;
                $display("[TB] FAIL rnd_wakeup cyc=%0d got=%0b/%0d exp=%0b/%0d", cyc, wkValid, wkPreg, expWk, expWkPreg);
            end
            checks++;
            if (errOvf !== modelOvf) begin
                failures++;
                $display("[TB] FAIL rnd_err_ovf cyc=%0d got=%0b exp=%0b", cyc, errOvf, modelOvf);
            end
            checks++;
            if (wkValid === 1'b1) wkSeen++;
            if (cyc == 10000) break;

            pip     = $urandom_range(0, 3);
            preg    = 6'($urandom);
            data    = $urandom;
            wbReady = 1'($urandom_range(0, 1));
            if (pip == 0) begin
                driveIdle();
                pregRd = preg;
            end else begin
                driveFill(pip, preg, data);
            end
            if (expQ.size() != 0 && wbReady) begin
                void'(expQ.pop_front());
            end
            if (pip != 0) begin
                accepted++;
                if (expQ.size() < 4) begin
                    e.preg = preg;
                    e.data = data;
                    expQ.push_back(e);
                end else begin
                    modelOvf = 1'b1;
                end
            end
            expWk     = (pip != 0);
            expWkPreg = preg;
            tick();
        end
        if (wkSeen != accepted) begin
            failures++;
            $display("[TB] FAIL rnd_wakeup_count got=%0d exp=%0d", wkSeen, accepted);
        end
        checks++;
        driveIdle();
        wbReady = 1'b0;
    endtask

    initial begin
        clearN    = 1'b0;
        wbReady   = 1'b0;
        insertPip = 3'd0;
        pregRd    = 6'd0;
        pipData   = '0;
        tick();
        test_reset();
        test_single_fill();
        test_overflow();
        test_back_to_back();
        test_bad_pip();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guards against a hung run; the normal sequence ends far earlier.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
